y_mem_wb: RTL and testbench
===========================

Name: y_mem_wb

Overview:
- Memory-access and writeback stage directly downstream of yEX; consumes the ALU result z, store data rd2 and the control bits decoded from ins.
- Performs RISC-V loads and stores (byte/half/word) against an internal data memory with a configurable wait-state count.
- Returns the writeback value, destination register and write enable that drive yID's wd/RegWrite inputs.
- Valid/ready handshake on the input side, one-cycle valid pulse on the output side.

Parameters:
- DEPTH, 256, data memory size in 32-bit words (power of two).
- MEM_LAT, 1, extra wait cycles per memory access (0..15).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX result presented.
- in_ready  out  1  stage can accept this cycle.
- z  in  32  ALU result / byte address.
- rd2  in  32  store data.
- rd  in  5  destination register.
- funct3  in  3  ins[14:12]; access size and sign.
- mem_read  in  1  load.
- mem_write  in  1  store.
- reg_write  in  1  instruction writes a register.
- mem_to_reg  in  1  1 = writeback load data, 0 = writeback z.
- wd  out  32  writeback data.
- wb_rd  out  5  writeback register.
- wb_we  out  1  register write enable, valid with out_valid.
- out_valid  out  1  one-cycle pulse, writeback outputs valid.
- misalign  out  1  held with out_valid; access was misaligned.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, wb_we=0, misalign=0, wd=0, wb_rd=0, wait counter=0. Memory contents are not reset.
- States: IDLE, ACCESS, WB. in_ready = (state==IDLE || state==WB).
- Accept when in_valid && in_ready: all inputs are registered.
  - Non-memory op or misaligned access: next state WB.
  - Memory op: next state ACCESS, counter=MEM_LAT.
- ACCESS: counter decrements each cycle. When counter==0, the next edge does the following and then moves to WB:
  - Store: writes memory with byte enables.
  - Load: captures the extended read data.
- ACCESS lasts exactly MEM_LAT+1 cycles.
- WB: out_valid=1 for exactly one cycle.
  - With a new accept in that cycle, the next state is ACCESS or WB per the new op; otherwise IDLE.
  - Back-to-back ALU ops therefore give one out_valid per cycle.
- Latency:
  - ALU op accepted at edge E0: out_valid high in the cycle after E0.
  - Memory op: out_valid high after E0+MEM_LAT+2 edges.
- Address: word index = z[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4.
- Sizes (funct3):
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Signed loads sign-extend, unsigned loads zero-extend.
  - Lane selected by z[1:0].
  - Other funct3 values with mem_read or mem_write are treated as word access.
- Misalignment:
  - Half with z[0]=1, or word with z[1:0]!=0.
  - No memory write occurs and ACCESS is skipped.
  - misalign=1 and wb_we=0 at WB.
- wd = mem_to_reg ? load data : z.
- wb_we = reg_write && rd!=0 && !misalign.
- mem_read and mem_write both set: handled as a store, with wb_we forced to 0.
- Reset asserted mid-ACCESS: pending store is discarded (memory unchanged), out_valid is never raised for it.

Decomposition:
- Package y_mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and state encoding (ST_IDLE, ST_ACCESS, ST_WB).
- Sub-module y_dmem:
  - DEPTH x 32 RAM with 4-bit byte enable.
  - Synchronous write, combinational read.
  - Instantiated once.
- Extension, alignment check and FSM stay in y_mem_wb.

Test Plan:
- Reset then ALU op (z=0x1234, rd=5, reg_write=1, mem_to_reg=0) -> out_valid on the next cycle; wd=0x1234, wb_rd=5, wb_we=1; in_ready stays 1.
- SW z=0x10, rd2=0xDEADBEEF, then LW z=0x10 with MEM_LAT=1 -> each out_valid comes 3 edges after accept; load wd=0xDEADBEEF; in_ready=0 during ACCESS.
- SB z=0x21, rd2=0x80, then LB and LBU at 0x21 -> LB wd=0xFFFFFF80, LBU wd=0x00000080; other bytes of word 8 unchanged.
- LW z=0x22 -> misalign=1, wb_we=0, out_valid one cycle after accept, memory untouched. Address z=DEPTH*4+0x10 aliases word 4 (wrap).
- Load with rd=0 -> wb_we=0. Three back-to-back ALU ops -> three consecutive out_valid pulses.
- SW issued, reset asserted during ACCESS -> outputs return to reset values immediately; later LW of that address returns the prior contents.

Source files
------------

// File: rtl/y_mem_pkg.sv
// ---------------------------------------------------------------------------
// y_mem_pkg
// Shared definitions for the memory-access / writeback stage:
//   - funct3 encodings for load/store access size and signedness
//   - FSM state encoding
//   - helper functions for size decode, alignment check, store lane
//     steering and load extension
// ---------------------------------------------------------------------------
package y_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Unlisted funct3 codes fall back to a full-word access.
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
        logic m;
        case (sz)
            SZ_H:    m = a[0];
            SZ_W:    m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] store_be(input size_e sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store value across all lanes; byte enables pick the lane.
    function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'd0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y_dmem.sv
// ---------------------------------------------------------------------------
// y_dmem
// DEPTH x 32-bit data memory, synchronous byte-enabled write,
// combinational read. Contents are not reset.
// Ports:
//   clk      write clock
//   we_i     write enable
//   addr_i   word index
//   be_i     per-byte write enables
//   wdata_i  write data (lane-steered by the caller)
//   rdata_o  read data at addr_i
// ---------------------------------------------------------------------------
module y_dmem #(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/y_mem_wb.sv
// ---------------------------------------------------------------------------
// y_mem_wb
// Memory-access and writeback stage. Accepts an EX result with a
// valid/ready handshake, performs an optional byte/half/word load or store
// against the internal data memory (MEM_LAT extra wait cycles), and presents
// the writeback value for one cycle with out_valid.
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid / in_ready        input handshake
//   z, rd2, rd, funct3         ALU result/address, store data, dest reg, size
//   mem_read, mem_write        load / store
//   reg_write, mem_to_reg      writeback control
//   wd, wb_rd, wb_we           writeback data, register, enable
//   out_valid                  one-cycle pulse, writeback outputs valid
//   misalign                   access was misaligned (valid with out_valid)
// ---------------------------------------------------------------------------
module y_mem_wb
    import y_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] z,
    input  logic [31:0] rd2,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    output logic [31:0] wd,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic        out_valid,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Captured operation
    logic [31:0] z_q, rd2_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic        st_q, m2r_q, wbreq_q;

    // Registered outputs
    logic [31:0] wd_q, wd_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_we_q, wb_we_d;
    logic        ov_q, ov_d;
    logic        mis_q, mis_d;

    logic        acc_s, new_mem_s, new_mis_s, new_we_s, fire_s;
    logic [31:0] rdata_s, ext_s;
    size_e       sz_q_s;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_WB);
    assign acc_s     = in_valid && in_ready;
    assign new_mem_s = mem_read || mem_write;
    assign new_mis_s = new_mem_s && is_misaligned(f3_size(funct3), z[1:0]);
    // Read+write together is a store and never writes back.
    assign new_we_s  = reg_write && (rd != 5'd0) && !(mem_read && mem_write);
    // Final ACCESS cycle: the memory operation happens on the coming edge.
    assign fire_s    = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign sz_q_s    = f3_size(f3_q);
    assign ext_s     = load_extend(rdata_s, f3_q, z_q[1:0]);

    y_dmem #(.DEPTH(DEPTH)) u_dmem (
        .clk     (clk),
        .we_i    (fire_s && st_q),
        .addr_i  (z_q[AW+1:2]),
        .be_i    (store_be(sz_q_s, z_q[1:0])),
        .wdata_i (store_data(sz_q_s, rd2_q)),
        .rdata_o (rdata_s)
    );

    // State, wait counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wd_q    <= 32'd0;
            wb_rd_q <= 5'd0;
            wb_we_q <= 1'b0;
            ov_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            wb_rd_q <= wb_rd_d;
            wb_we_q <= wb_we_d;
            ov_q    <= ov_d;
            mis_q   <= mis_d;
        end
    end

    // Capture the accepted operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_q     <= 32'd0;
            rd2_q   <= 32'd0;
            rd_q    <= 5'd0;
            f3_q    <= 3'd0;
            st_q    <= 1'b0;
            m2r_q   <= 1'b0;
            wbreq_q <= 1'b0;
        end else if (acc_s) begin
            z_q     <= z;
            rd2_q   <= rd2;
            rd_q    <= rd;
            f3_q    <= funct3;
            st_q    <= mem_write;
            m2r_q   <= mem_to_reg;
            wbreq_q <= new_we_s;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_WB: begin
                if (acc_s) begin
                    if (new_mem_s && !new_mis_s) begin
                        state_d = ST_ACCESS;
                        cnt_d   = MEM_LAT[3:0];
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Writeback outputs, computed for the cycle in which WB is entered.
    always_comb begin
        wd_d    = wd_q;
        wb_rd_d = wb_rd_q;
        wb_we_d = 1'b0;
        ov_d    = 1'b0;
        mis_d   = 1'b0;
        if (state_d == ST_WB) begin
            ov_d = 1'b1;
            if (state_q == ST_ACCESS) begin
                wd_d    = m2r_q ? ext_s : z_q;
                wb_rd_d = rd_q;
                wb_we_d = wbreq_q;
            end else begin
                // Direct from accept: ALU op or misaligned access (no load data).
                wd_d    = mem_to_reg ? 32'd0 : z;
                wb_rd_d = rd;
                wb_we_d = new_we_s && !new_mis_s;
                mis_d   = new_mis_s;
            end
        end else begin
            ov_d = 1'b0;
        end
    end

    assign wd        = wd_q;
    assign wb_rd     = wb_rd_q;
    assign wb_we     = wb_we_q;
    assign out_valid = ov_q;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_y_mem_wb.sv
module tb_y_mem_wb;

    localparam int DEPTH   = 256;
    localparam int MEM_LAT = 1;
    localparam int MLAT    = MEM_LAT + 1;   // edges from accept to WB for memory ops

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] z = 32'd0, rd2 = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, mem_to_reg = 1'b0;
    logic [31:0] wd;
    logic [4:0]  wb_rd;
    logic        wb_we, out_valid, misalign;

    typedef struct {
        string       nm;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        we;
        logic        mis;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    y_mem_wb #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .z(z), .rd2(rd2), .rd(rd), .funct3(funct3),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .wd(wd), .wb_rd(wb_rd), .wb_we(wb_we),
        .out_valid(out_valid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Issue one op at a negedge once in_ready is seen; pushes the expected result.
    task automatic issue(input string nm, input logic [31:0] zz, input logic [31:0] dd,
                         input logic [4:0] rr, input logic [2:0] f3,
                         input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic [31:0] e_wd, input logic e_we, input logic e_mis,
                         input int e_lat);
        exp_t e;
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: in_ready timeout, got %0b required 1", nm, in_ready);
        end else begin
            z = zz; rd2 = dd; rd = rr; funct3 = f3;
            mem_read = mr; mem_write = mw; reg_write = rw; mem_to_reg = m2r;
            in_valid = 1'b1;
            e.nm = nm; e.wd = e_wd; e.rd = rr; e.we = e_we; e.mis = e_mis;
            e.lat = e_lat; e.acc = cyc + 1;
            sb.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
        end
    endtask

    task automatic chk_ready(input string nm, input logic req);
        n_cmp++;
        if (in_ready !== req) begin
            n_bad++;
            $display("FAIL %s: in_ready got %0b required %0b", nm, in_ready, req);
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || wb_we !== 1'b0 ||
            misalign !== 1'b0 || wd !== 32'd0 || wb_rd !== 5'd0) begin
            n_bad++;
            $display("FAIL %s: got rdy=%0b ov=%0b we=%0b mis=%0b wd=%h rd=%0d required 1 0 0 0 00000000 0",
                     nm, in_ready, out_valid, wb_we, misalign, wd, wb_rd);
        end
    endtask

    initial begin
        fork
            // Monitor: pop and compare whenever the DUT presents a result.
            forever begin
                @(negedge clk);
                if (out_valid === 1'b1) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_out: got wd=%h rd=%0d with no pending op", wd, wb_rd);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (wd !== e.wd || wb_rd !== e.rd || wb_we !== e.we ||
                            misalign !== e.mis || (cyc - e.acc) != e.lat) begin
                            n_bad++;
                            $display("FAIL %s: got wd=%h rd=%0d we=%0b mis=%0b lat=%0d required wd=%h rd=%0d we=%0b mis=%0b lat=%0d",
                                     e.nm, wd, wb_rd, wb_we, misalign, cyc - e.acc,
                                     e.wd, e.rd, e.we, e.mis, e.lat);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_reset_outs("reset_state");
        reset = 1'b0;
        @(negedge clk);

        //    name        z             rd2           rd     f3      mr    mw    rw    m2r   e_wd          we    mis   lat
        issue("alu",      32'h1234,     32'd0,        5'd5,  3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234,     1'b1, 1'b0, 0);
        chk_ready("alu_ready", 1'b1);
        issue("sw_10",    32'h10,       32'hDEADBEEF, 5'd0,  3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10,       1'b0, 1'b0, MLAT);
        chk_ready("sw_busy", 1'b0);
        issue("lw_10",    32'h10,       32'd0,        5'd6,  3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, MLAT);
        chk_ready("lw_busy", 1'b0);
        issue("sw_20",    32'h20,       32'h11223344, 5'd0,  3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20,       1'b0, 1'b0, MLAT);
        issue("sb_21",    32'h21,       32'h00000080, 5'd0,  3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h21,       1'b0, 1'b0, MLAT);
        issue("lb_21",    32'h21,       32'd0,        5'd7,  3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0, MLAT);
        issue("lbu_21",   32'h21,       32'd0,        5'd8,  3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000080, 1'b1, 1'b0, MLAT);
        issue("lw_20",    32'h20,       32'd0,        5'd9,  3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11228044, 1'b1, 1'b0, MLAT);
        issue("lw_mis",   32'h22,       32'd0,        5'd10, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b1, 0);
        issue("sw_mis",   32'h22,       32'hFFFFFFFF, 5'd0,  3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h22,       1'b0, 1'b1, 0);
        issue("lw_20b",   32'h20,       32'd0,        5'd11, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11228044, 1'b1, 1'b0, MLAT);
        issue("lh_22",    32'h22,       32'd0,        5'd12, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00001122, 1'b1, 1'b0, MLAT);
        issue("lh_20",    32'h20,       32'd0,        5'd13, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF8044, 1'b1, 1'b0, MLAT);
        issue("lhu_20",   32'h20,       32'd0,        5'd14, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00008044, 1'b1, 1'b0, MLAT);
        issue("lw_wrap",  DEPTH*4+32'h10, 32'd0,      5'd15, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, MLAT);
        issue("lw_rd0",   32'h10,       32'd0,        5'd0,  3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, MLAT);
        issue("alu_b2b1", 32'h1,        32'd0,        5'd1,  3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1,        1'b1, 1'b0, 0);
        issue("alu_b2b2", 32'h2,        32'd0,        5'd2,  3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2,        1'b1, 1'b0, 0);
        issue("alu_b2b3", 32'h3,        32'd0,        5'd3,  3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3,        1'b1, 1'b0, 0);
        issue("rw_both",  32'h40,       32'h55AA55AA, 5'd7,  3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40,       1'b0, 1'b0, MLAT);
        issue("lw_40",    32'h40,       32'd0,        5'd16, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55AA55AA, 1'b1, 1'b0, MLAT);
        issue("sw_30",    32'h30,       32'h11112222, 5'd0,  3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h30,       1'b0, 1'b0, MLAT);
        issue("lw_30",    32'h30,       32'd0,        5'd17, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11112222, 1'b1, 1'b0, MLAT);

        // Store interrupted by reset while in ACCESS: its result must never appear.
        issue("sw_30_rst", 32'h30,      32'hCAFEF00D, 5'd0,  3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h30,       1'b0, 1'b0, MLAT);
        chk_ready("sw_rst_busy", 1'b0);
        reset = 1'b1;
        if (sb.size() > 0) void'(sb.pop_back());
        #1;
        chk_reset_outs("mid_access_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue("lw_30_post", 32'h30,     32'd0,        5'd18, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11112222, 1'b1, 1'b0, MLAT);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no out_valid seen, required wd=%h", e.nm, e.wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
